imu_uart2bram: RTL and testbench

//  Receive side of the IMU UART link: deserialises 8N1 UART bytes from rx_uart, pairs them

---
 rtl/imu_uart2bram.sv | 192 +++++++++++++++++++
 tb/tb_imu_uart2bram.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_uart2bram.sv
// imu_uart2bram
//   Receive side of the IMU UART link. Deserialises 8N1 bytes from rx_uart,
//   pairs them into 16-bit words (high byte first) and writes them to
//   consecutive addresses of a 16-bit BRAM write port.
// Ports
//   clk, rst        : system clock, synchronous active-low reset
//   active_bit      : receiver enable; low holds the RX FSM idle and drops state
//   addr_clr        : 1-cycle pulse, clears address, word_count and wrap
//   rx_uart         : asynchronous UART line, idle high
//   data_bram/addr_bram/en_bram/we_bram : BRAM write port (one pulse per word)
//   word_count      : words written since reset/addr_clr, saturating
//   frame_err       : 1-cycle pulse when a stop bit is sampled low
//   wrap            : sticky flag, write address wrapped to 0
module imu_uart2bram #(
    parameter int ADDR_WIDTH   = 13,
    parameter int CLK_FREQ     = 125000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active_bit,
    input  logic                  addr_clr,
    input  logic                  rx_uart,
    output logic [15:0]           data_bram,
    output logic [ADDR_WIDTH-1:0] addr_bram,
    output logic                  en_bram,
    output logic                  we_bram,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  frame_err,
    output logic                  wrap
);

    localparam int CPB    = CLK_FREQ / BAUD;
    localparam int CW     = $clog2(CPB + 1);
    localparam int TO_CYC = TIMEOUT_BITS * CPB;
    localparam int TW     = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    logic                  rx_s1_q, rx_s2_q;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            sh_q, sh_d;
    logic                  bv_q, bv_d;
    logic                  fe_q, fe_d;

    logic                  phase_q;
    logic [7:0]            hi_q;
    logic [TW-1:0]         to_q;
    logic                  en_q;
    logic [15:0]           data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   wc_q;
    logic                  wrap_q;

    // RX FSM: next state / datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        bv_d    = 1'b0;
        fe_d    = 1'b0;
        if (!active_bit) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (!rx_s2_q) state_d = S_START;
                end
                S_START: begin
                    // mid start bit: a line already back high was a glitch
                    if (cnt_q == CW'(CPB / 2 - 1)) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_s2_q ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CW'(CPB - 1)) begin
                        cnt_d = '0;
                        sh_d  = {rx_s2_q, sh_q[7:1]};
                        bit_d = bit_q + 1'b1;
                        if (bit_q == 3'd7) state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CW'(CPB - 1)) begin
                        cnt_d = '0;
                        if (rx_s2_q) begin
                            bv_d    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // a held-low line must return high before a new frame
                    cnt_d = '0;
                    if (rx_s2_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            bv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            rx_s1_q <= rx_uart;
            rx_s2_q <= rx_s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            bv_q    <= bv_d;
            fe_q    <= fe_d;
        end
    end

    // Byte pairing, timeout and write port
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
            to_q    <= '0;
            en_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            wc_q    <= '0;
            wrap_q  <= 1'b0;
        end else begin
            en_q <= 1'b0;
            if (!active_bit || fe_q) begin
                phase_q <= 1'b0;
                to_q    <= '0;
            end else if (bv_q) begin
                to_q <= '0;
                if (!phase_q) begin
                    hi_q    <= sh_q;
                    phase_q <= 1'b1;
                end else begin
                    phase_q <= 1'b0;
                    data_q  <= {hi_q, sh_q};
                    en_q    <= 1'b1;
                end
            end else if (phase_q) begin
                // stale high byte is dropped so the stream re-aligns
                if (to_q == TW'(TO_CYC - 1)) begin
                    phase_q <= 1'b0;
                    to_q    <= '0;
                end else begin
                    to_q <= to_q + 1'b1;
                end
            end

            // clear takes priority over the post-strobe increment
            if (addr_clr) begin
                addr_q <= '0;
                wc_q   <= '0;
                wrap_q <= 1'b0;
            end else if (en_q) begin
                addr_q <= addr_q + 1'b1;
                if (&addr_q) wrap_q <= 1'b1;
                if (!(&wc_q)) wc_q <= wc_q + 1'b1;
            end
        end
    end

    assign data_bram  = data_q;
    assign addr_bram  = addr_q;
    assign en_bram    = en_q;
    assign we_bram    = en_q;
    assign word_count = wc_q;
    assign frame_err  = fe_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_imu_uart2bram.sv
// Self-checking bench for imu_uart2bram: byte-level reference model of the
// word assembler, a per-cycle compare process on the BRAM port, and
// directed/random UART traffic.
module tb_imu_uart2bram;

    localparam int AW  = 4;
    localparam int CF  = 1600;
    localparam int BD  = 100;
    localparam int CPB = CF / BD;   // 16 clocks per bit
    localparam int TOB = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          active_bit = 1'b0;
    logic          addr_clr = 1'b0;
    logic          rx_uart = 1'b1;
    logic [15:0]   data_bram;
    logic [AW-1:0] addr_bram;
    logic          en_bram, we_bram;
    logic [AW:0]   word_count;
    logic          frame_err, wrap;

    imu_uart2bram #(.ADDR_WIDTH(AW), .CLK_FREQ(CF), .BAUD(BD), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk), .rst(rst), .active_bit(active_bit), .addr_clr(addr_clr),
        .rx_uart(rx_uart), .data_bram(data_bram), .addr_bram(addr_bram),
        .en_bram(en_bram), .we_bram(we_bram), .word_count(word_count),
        .frame_err(frame_err), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit              m_phase = 0;
    logic [7:0]      m_hi = '0;
    int              m_addr = 0;
    int              m_wc = 0;
    bit              m_wrap = 0;
    int              fe_exp = 0;
    logic [AW+15:0]  exp_q[$];

    // observed by compare process
    int              fe_seen = 0;
    bit              chk_en = 0;
    bit              have_last = 0;
    logic [15:0]     last_data = '0;
    logic [AW-1:0]   last_addr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("we_eq_en", 32'(we_bram), 32'(en_bram));
            if (frame_err) fe_seen++;
            if (en_bram) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(1), 32'(0));
                end else begin
                    logic [AW+15:0] e;
                    e = exp_q.pop_front();
                    chk("strobe_addr", 32'(addr_bram), 32'(e[AW+15:16]));
                    chk("strobe_data", 32'(data_bram), 32'(e[15:0]));
                end
                have_last = 1;
                last_data = data_bram;
                last_addr = addr_bram;
            end else if (have_last) begin
                chk("data_hold", 32'(data_bram), 32'(last_data));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected effect of one frame; gap = idle bit-times preceding it.
    // Pair distance is gap+10 bit-times, so gaps <=3 pair and >=14 time out.
    task automatic model_byte(input logic [7:0] b, input bit ok, input int gap);
        if (m_phase && gap >= 14) m_phase = 0;
        if (!ok) begin
            fe_exp++;
            m_phase = 0;
        end else if (!m_phase) begin
            m_hi = b;
            m_phase = 1;
        end else begin
            exp_q.push_back({AW'(m_addr), m_hi, b});
            m_phase = 0;
            if (m_addr == (1 << AW) - 1) m_wrap = 1;
            m_addr = (m_addr + 1) % (1 << AW);
            if (m_wc < (1 << (AW + 1)) - 1) m_wc++;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit ok, input int gap);
        model_byte(b, ok, gap);
        rx_uart = 1'b1;
        wait_cyc(gap * CPB);
        rx_uart = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_uart = b[i];
            wait_cyc(CPB);
        end
        rx_uart = ok;
        wait_cyc(CPB);
        rx_uart = 1'b1;
    endtask

    task automatic clear_addr();
        addr_clr = 1'b1;
        wait_cyc(1);
        addr_clr = 1'b0;
        m_addr = 0;
        m_wc = 0;
        m_wrap = 0;
    endtask

    task automatic checkpoint(input string nm);
        wait_cyc(4);
        chk({nm, "_addr"}, 32'(addr_bram), 32'(m_addr));
        chk({nm, "_wc"}, 32'(word_count), 32'(m_wc));
        chk({nm, "_wrap"}, 32'(wrap), 32'(m_wrap));
        chk({nm, "_ferr"}, 32'(fe_seen), 32'(fe_exp));
        chk({nm, "_pending"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int fe0;
        // reset
        wait_cyc(5);
        @(negedge clk);
        chk("rst_data", 32'(data_bram), 32'(0));
        chk("rst_addr", 32'(addr_bram), 32'(0));
        chk("rst_en", 32'({en_bram, we_bram, frame_err, wrap}), 32'(0));
        chk("rst_wc", 32'(word_count), 32'(0));
        rst = 1'b1;
        active_bit = 1'b1;
        wait_cyc(2);
        chk_en = 1;

        // 1) single word
        send(8'h12, 1, 1);
        send(8'h34, 1, 1);
        checkpoint("t1");
        chk("t1_data_lit", 32'(last_data), 32'h1234);
        chk("t1_wc_lit", 32'(word_count), 32'd1);

        // 2) three words
        clear_addr();
        send(8'h12, 1, 1); send(8'h34, 1, 2);
        send(8'h56, 1, 1); send(8'h78, 1, 3);
        send(8'h9A, 1, 1); send(8'hBC, 1, 1);
        checkpoint("t2");
        chk("t2_last_addr_lit", 32'(last_addr), 32'd2);
        chk("t2_addr_lit", 32'(addr_bram), 32'd3);
        chk("t2_data_lit", 32'(last_data), 32'h9ABC);

        // 3) short glitch on idle line
        fe0 = fe_seen;
        rx_uart = 1'b0;
        wait_cyc(3);
        rx_uart = 1'b1;
        wait_cyc(2 * CPB);
        chk("t3_no_ferr", 32'(fe_seen), 32'(fe0));
        checkpoint("t3");

        // 4) framing error then a good pair at address 0
        clear_addr();
        send(8'h5A, 0, 1);
        send(8'h11, 1, 2);
        send(8'h22, 1, 1);
        checkpoint("t4");
        chk("t4_ferr_lit", 32'(fe_seen - fe0), 32'd1);
        chk("t4_addr_lit", 32'(last_addr), 32'd0);
        chk("t4_data_lit", 32'(last_data), 32'h1122);

        // 5) lone byte times out
        clear_addr();
        send(8'h77, 1, 1);
        send(8'hAB, 1, 25);
        send(8'hCD, 1, 1);
        checkpoint("t5");
        chk("t5_data_lit", 32'(last_data), 32'hABCD);
        chk("t5_wc_lit", 32'(word_count), 32'd1);

        // active_bit drop mid-frame discards pending high byte
        send(8'h55, 1, 1);
        m_phase = 0;
        rx_uart = 1'b0;
        wait_cyc(3 * CPB);
        active_bit = 1'b0;
        wait_cyc(2);
        rx_uart = 1'b1;
        wait_cyc(2 * CPB);
        active_bit = 1'b1;
        send(8'h66, 1, 1);
        send(8'h77, 1, 1);
        checkpoint("abort");
        chk("abort_data_lit", 32'(last_data), 32'h6677);

        // 6) fill all addresses, wrap, clear
        clear_addr();
        for (int i = 0; i < (1 << AW); i++) begin
            send(8'($urandom), 1, 1);
            send(8'($urandom), 1, 1);
        end
        checkpoint("t6");
        chk("t6_wrap_lit", 32'(wrap), 32'd1);
        chk("t6_addr_lit", 32'(addr_bram), 32'd0);
        chk("t6_lastaddr_lit", 32'(last_addr), 32'd15);
        clear_addr();
        checkpoint("t6clr");
        chk("t6clr_wrap_lit", 32'(wrap), 32'd0);

        // word_count saturation
        for (int i = 0; i < 34; i++) begin
            send(8'($urandom), 1, 1);
            send(8'($urandom), 1, 1);
        end
        checkpoint("sat");
        chk("sat_wc_lit", 32'(word_count), 32'd31);
        chk("sat_addr_lit", 32'(addr_bram), 32'd2);

        // random traffic
        for (int i = 0; i < 70; i++) begin
            int r, g;
            bit ok;
            r  = $urandom_range(0, 99);
            ok = ($urandom_range(0, 9) != 0);
            g  = (r < 15) ? $urandom_range(14, 18) : $urandom_range(1, 3);
            if ($urandom_range(0, 19) == 0) clear_addr();
            send(8'($urandom), ok, g);
        end
        checkpoint("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
